// File: rtl/pwm_pkg.sv
// Shared PWM definitions: FSM state encodings and the 8-bit duty scale.
// Shared by the capture block (pwm_capture) and the PWM generator.
package pwm_pkg;

   localparam int unsigned DUTY_W = 8;
   localparam logic [DUTY_W-1:0] DUTY_FULL = 8'd255;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WAIT_RISE = 2'd1,
      MEASURE   = 2'd2
   } pwm_state_e;

endpackage

// File: rtl/pwm_capture_if.sv
// Bus between the PWM capture block and user logic / the pin side.
interface pwm_capture_if
   import pwm_pkg::*;
#(
   parameter int unsigned CNT_W = 24
);
   logic              enable;
   logic              pwm_in;
   logic [CNT_W-1:0]  high_count;
   logic [CNT_W-1:0]  period_count;
   logic              valid;
   logic              stuck_high;
   logic              stuck_low;
   logic [DUTY_W-1:0] duty;
   logic              duty_valid;

   modport master (
      output enable, pwm_in,
      input  high_count, period_count, valid, stuck_high, stuck_low, duty, duty_valid
   );

   modport slave (
      input  enable, pwm_in,
      output high_count, period_count, valid, stuck_high, stuck_low, duty, duty_valid
   );
endinterface

// File: rtl/pwm_seq_div.sv
// Restoring sequential divider, one quotient bit per cycle.
// done pulses W+1 cycles after start, with quotient updated in the same cycle.
// A start while busy abandons the running divide and reloads the operands.
module pwm_seq_div #(
   parameter int unsigned W   = 32,
   parameter int unsigned Q_W = 8
) (
   input  logic           clock,
   input  logic           reset_n,
   input  logic           start,
   input  logic [W-1:0]   dividend,
   input  logic [W-1:0]   divisor,
   output logic [Q_W-1:0] quotient,
   output logic           done
);
   localparam int unsigned CW = $clog2(W + 1);

   logic           busy_q, busy_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [W-1:0]   rem_q, rem_d;
   logic [W-1:0]   dq_q, dq_d;
   logic [W-1:0]   dvs_q, dvs_d;
   logic [Q_W-1:0] quo_q, quo_d;
   logic           done_q, done_d;

   logic [W:0]     rem_sh_c;
   logic [W:0]     diff_c;
   logic           q_bit_c;
   logic [W-1:0]   dq_nx_c;

   // One restoring step: shift in the next dividend bit, trial-subtract the divisor
   always_comb begin
      rem_sh_c = {rem_q, dq_q[W-1]};
      diff_c   = rem_sh_c - {1'b0, dvs_q};
      q_bit_c  = ~diff_c[W];
      dq_nx_c  = {dq_q[W-2:0], q_bit_c};
   end

   // Load on start, iterate while busy, publish quotient on the last step
   always_comb begin
      busy_d = busy_q;
      cnt_d  = cnt_q;
      rem_d  = rem_q;
      dq_d   = dq_q;
      dvs_d  = dvs_q;
      quo_d  = quo_q;
      done_d = 1'b0;
      if (start) begin
         busy_d = 1'b1;
         cnt_d  = CW'(W);
         rem_d  = '0;
         dq_d   = dividend;
         dvs_d  = divisor;
      end else if (busy_q) begin
         rem_d = q_bit_c ? diff_c[W-1:0] : rem_sh_c[W-1:0];
         dq_d  = dq_nx_c;
         cnt_d = cnt_q - CW'(1);
         if (cnt_q == CW'(1)) begin
            busy_d = 1'b0;
            done_d = 1'b1;
            quo_d  = dq_nx_c[Q_W-1:0];
         end
      end
   end

   // Divider state registers
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         busy_q <= 1'b0;
         cnt_q  <= '0;
         rem_q  <= '0;
         dq_q   <= '0;
         dvs_q  <= '0;
         quo_q  <= '0;
         done_q <= 1'b0;
      end else begin
         busy_q <= busy_d;
         cnt_q  <= cnt_d;
         rem_q  <= rem_d;
         dq_q   <= dq_d;
         dvs_q  <= dvs_d;
         quo_q  <= quo_d;
         done_q <= done_d;
      end
   end

   assign quotient = quo_q;
   assign done     = done_q;
endmodule

// File: rtl/pwm_capture.sv
// PWM receiver: measures high time and period of an asynchronous PWM input.
// Optional duty-cycle divider enabled by defining PWM_CAPTURE_DUTY_EN;
// without it duty and duty_valid are tied to 0.
module pwm_capture
   import pwm_pkg::*;
#(
   parameter int unsigned CNT_W       = 24,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic          clock,
   input  logic          reset_n,
   pwm_capture_if.slave  bus
);
   localparam logic [CNT_W-1:0] MAX = '1;

   pwm_state_e             state_q, state_d;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   s_dly_q;
   logic [CNT_W-1:0]       cnt_p_q, cnt_p_d;
   logic [CNT_W-1:0]       cnt_h_q, cnt_h_d;
   logic [CNT_W-1:0]       high_q, high_d;
   logic [CNT_W-1:0]       period_q, period_d;
   logic                   valid_q, valid_d;
   logic                   stuck_high_q, stuck_high_d;
   logic                   stuck_low_q, stuck_low_d;
   logic                   s_c;
   logic                   rise_c;

   assign s_c    = sync_q[SYNC_STAGES-1];
   assign rise_c = s_c & ~s_dly_q;

   // Synchronizer chain plus one delay flop for edge detection
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sync_q  <= '0;
         s_dly_q <= 1'b0;
      end else begin
         sync_q  <= {sync_q[SYNC_STAGES-2:0], bus.pwm_in};
         s_dly_q <= s_c;
      end
   end

   // Next-state, counters and result latching; a rise beats the timeout
   always_comb begin
      state_d      = state_q;
      cnt_p_d      = cnt_p_q;
      cnt_h_d      = cnt_h_q;
      high_d       = high_q;
      period_d     = period_q;
      valid_d      = 1'b0;
      stuck_high_d = stuck_high_q;
      stuck_low_d  = stuck_low_q;
      if (!bus.enable) begin
         state_d = IDLE;
         cnt_p_d = '0;
         cnt_h_d = '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               cnt_p_d = '0;
               cnt_h_d = '0;
               state_d = WAIT_RISE;
            end
            WAIT_RISE: begin
               if (rise_c) begin
                  state_d = MEASURE;
                  cnt_p_d = CNT_W'(1);
                  cnt_h_d = CNT_W'(1);
               end
            end
            MEASURE: begin
               if (rise_c) begin
                  high_d       = cnt_h_q;
                  period_d     = cnt_p_q;
                  valid_d      = 1'b1;
                  stuck_high_d = 1'b0;
                  stuck_low_d  = 1'b0;
                  cnt_p_d      = CNT_W'(1);
                  cnt_h_d      = CNT_W'(1);
               end else if (cnt_p_q == MAX) begin
                  period_d     = MAX;
                  high_d       = s_c ? MAX : '0;
                  stuck_high_d = s_c;
                  stuck_low_d  = ~s_c;
                  valid_d      = 1'b1;
                  cnt_p_d      = '0;
                  cnt_h_d      = '0;
                  state_d      = WAIT_RISE;
               end else begin
                  cnt_p_d = cnt_p_q + CNT_W'(1);
                  if (s_c && (cnt_h_q != MAX)) begin
                     cnt_h_d = cnt_h_q + CNT_W'(1);
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // FSM, counter and output registers
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         cnt_p_q      <= '0;
         cnt_h_q      <= '0;
         high_q       <= '0;
         period_q     <= '0;
         valid_q      <= 1'b0;
         stuck_high_q <= 1'b0;
         stuck_low_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_p_q      <= cnt_p_d;
         cnt_h_q      <= cnt_h_d;
         high_q       <= high_d;
         period_q     <= period_d;
         valid_q      <= valid_d;
         stuck_high_q <= stuck_high_d;
         stuck_low_q  <= stuck_low_d;
      end
   end

   assign bus.high_count   = high_q;
   assign bus.period_count = period_q;
   assign bus.valid        = valid_q;
   assign bus.stuck_high   = stuck_high_q;
   assign bus.stuck_low    = stuck_low_q;

`ifdef PWM_CAPTURE_DUTY_EN
   localparam int unsigned DIV_W = CNT_W + DUTY_W;

   logic [DIV_W-1:0] dividend_c;
   logic [DIV_W-1:0] divisor_c;

   // duty = floor(high*255/period); each valid (re)starts the divide
   assign dividend_c = DIV_W'(high_q) * DIV_W'(DUTY_FULL);
   assign divisor_c  = DIV_W'(period_q);

   pwm_seq_div #(
      .W   (DIV_W),
      .Q_W (DUTY_W)
   ) u_div (
      .clock    (clock),
      .reset_n  (reset_n),
      .start    (valid_q),
      .dividend (dividend_c),
      .divisor  (divisor_c),
      .quotient (bus.duty),
      .done     (bus.duty_valid)
   );
`else
   assign bus.duty       = '0;
   assign bus.duty_valid = 1'b0;
`endif

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture (CNT_W=8 so timeouts are reachable quickly).
module tb_pwm_capture;
   localparam int unsigned CNT_W   = 8;
   localparam int          DIV_LAT = CNT_W + 9;
`ifdef PWM_CAPTURE_DUTY_EN
   localparam bit DUTY_EN = 1'b1;
`else
   localparam bit DUTY_EN = 1'b0;
`endif

   logic clock = 1'b0;
   logic reset_n;

   always #5 clock = ~clock;

   pwm_capture_if #(.CNT_W(CNT_W)) bus();

   pwm_capture #(
      .CNT_W       (CNT_W),
      .SYNC_STAGES (2)
   ) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   int n_assert = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int n_valid  = 0;
   int n_dvalid = 0;
   int v_cyc    = 0;
   int dv_cyc   = 0;
   int snap;
   int snap_dv;

   // Strobe monitor: counts valid / duty_valid pulses and when they last occurred
   always @(posedge clock) begin
      cyc <= cyc + 1;
      if (bus.valid === 1'b1) begin
         n_valid <= n_valid + 1;
         v_cyc   <= cyc;
      end
      if (bus.duty_valid === 1'b1) begin
         n_dvalid <= n_dvalid + 1;
         dv_cyc   <= cyc;
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic pwm_period(input int h, input int p);
      bus.pwm_in = 1'b1;
      step(h);
      bus.pwm_in = 1'b0;
      step(p - h);
   endtask

   task automatic check(input string tag, input int obs, input int exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n    = 1'b0;
      bus.enable = 1'b0;
      bus.pwm_in = 1'b0;
      step(3);
      check("rst_high",       32'(bus.high_count),   0);
      check("rst_period",     32'(bus.period_count), 0);
      check("rst_valid",      32'(bus.valid),        0);
      check("rst_stuck_high", 32'(bus.stuck_high),   0);
      check("rst_stuck_low",  32'(bus.stuck_low),    0);
      check("rst_duty",       32'(bus.duty),         0);
      check("rst_duty_valid", 32'(bus.duty_valid),   0);
      reset_n = 1'b1;
      step(2);
      bus.enable = 1'b1;
      step(3);

      // Steady 25/100 waveform
      snap = n_valid;
      pwm_period(25, 100);
      check("t2_no_valid_first_rise", n_valid, snap);
      pwm_period(25, 100);
      check("t2_one_valid",  n_valid, snap + 1);
      check("t2_high",       32'(bus.high_count),   25);
      check("t2_period",     32'(bus.period_count), 100);
      check("t2_stuck_high", 32'(bus.stuck_high),   0);
      check("t2_stuck_low",  32'(bus.stuck_low),    0);
      check("t2_duty",       32'(bus.duty), DUTY_EN ? 63 : 0);
`ifdef PWM_CAPTURE_DUTY_EN
      check("t2_duty_latency", dv_cyc - v_cyc, DIV_LAT);
`else
      check("t2_no_duty_valid", n_dvalid, 0);
`endif
      pwm_period(25, 100);
      check("t2_second_valid", n_valid, snap + 2);

      // Reset asserted mid-period
      bus.pwm_in = 1'b1;
      step(10);
      reset_n = 1'b0;
      #1;
      check("mrst_high",      32'(bus.high_count),   0);
      check("mrst_period",    32'(bus.period_count), 0);
      check("mrst_valid",     32'(bus.valid),        0);
      check("mrst_duty",      32'(bus.duty),         0);
      bus.pwm_in = 1'b0;
      step(3);
      reset_n = 1'b1;
      step(2);
      snap = n_valid;
      pwm_period(25, 100);
      check("mrst_no_valid_first_rise", n_valid, snap);
      pwm_period(25, 100);
      check("mrst_valid_second_rise", n_valid, snap + 1);
      check("mrst_high_after",        32'(bus.high_count),   25);
      check("mrst_period_after",      32'(bus.period_count), 100);

      // Enable dropped mid-period, then re-enabled
      bus.pwm_in = 1'b1;
      step(25);
      bus.pwm_in = 1'b0;
      step(20);
      bus.enable = 1'b0;
      snap = n_valid;
      step(55);
      pwm_period(25, 100);
      check("en_no_valid",    n_valid, snap);
      check("en_hold_high",   32'(bus.high_count),   25);
      check("en_hold_period", 32'(bus.period_count), 100);
      bus.enable = 1'b1;
      snap = n_valid;
      pwm_period(30, 60);
      check("en_no_valid_first_rise", n_valid, snap);
      pwm_period(30, 60);
      check("en_valid_second_rise", n_valid, snap + 1);
      check("en_high",   32'(bus.high_count),   30);
      check("en_period", 32'(bus.period_count), 60);
      check("en_duty",   32'(bus.duty), DUTY_EN ? 127 : 0);

      // Stuck low after a rise
      bus.pwm_in = 1'b1;
      step(10);
      bus.pwm_in = 1'b0;
      snap = n_valid;
      step(300);
      check("sl_one_valid",  n_valid, snap + 1);
      check("sl_stuck_low",  32'(bus.stuck_low),    1);
      check("sl_stuck_high", 32'(bus.stuck_high),   0);
      check("sl_high",       32'(bus.high_count),   0);
      check("sl_period",     32'(bus.period_count), 255);
      check("sl_duty",       32'(bus.duty),         0);
      pwm_period(20, 50);
      check("sl_no_valid_first_rise", n_valid, snap + 1);
      check("sl_still_stuck",         32'(bus.stuck_low), 1);
      pwm_period(20, 50);
      check("sl_recover_valid",  n_valid, snap + 2);
      check("sl_cleared",        32'(bus.stuck_low),    0);
      check("sl_recover_high",   32'(bus.high_count),   20);
      check("sl_recover_period", 32'(bus.period_count), 50);
      check("sl_recover_duty",   32'(bus.duty), DUTY_EN ? 102 : 0);

      // Stuck high
      bus.pwm_in = 1'b1;
      step(10);
      snap = n_valid;
      step(300);
      check("sh_one_valid",  n_valid, snap + 1);
      check("sh_stuck_high", 32'(bus.stuck_high),   1);
      check("sh_stuck_low",  32'(bus.stuck_low),    0);
      check("sh_high",       32'(bus.high_count),   255);
      check("sh_period",     32'(bus.period_count), 255);
      check("sh_duty",       32'(bus.duty), DUTY_EN ? 255 : 0);

      // Back-to-back valids closer than the divide time
      bus.pwm_in = 1'b0;
      step(10);
      snap    = n_valid;
      snap_dv = n_dvalid;
      pwm_period(3, 10);
      pwm_period(4, 12);
      pwm_period(1, 40);
      check("ab_two_valids",  n_valid, snap + 2);
      check("ab_high",        32'(bus.high_count),   4);
      check("ab_period",      32'(bus.period_count), 12);
      check("ab_one_dvalid",  n_dvalid, snap_dv + (DUTY_EN ? 1 : 0));
      check("ab_duty_latest", 32'(bus.duty), DUTY_EN ? 85 : 0);
`ifdef PWM_CAPTURE_DUTY_EN
      check("ab_duty_latency", dv_cyc - v_cyc, DIV_LAT);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
